// File: rtl/mcu_pkg.sv
// Shared MCU definitions: data-memory geometry and the bus ownership encoding
// used by everything that talks to the data RAM.
package mcu_pkg;

    localparam int DMEM_AW = 4;
    localparam int DMEM_DW = 8;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        CORE = 2'd1,
        HOST = 2'd2
    } owner_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Data-memory arbiter bus bundle: core port, host/debug port and RAM port.
// The slave modport is the arbiter's view; master is the surrounding system.
interface dmem_arbiter_if;

    logic                         core_req;
    logic                         core_we;
    logic [mcu_pkg::DMEM_AW-1:0]  core_addr;
    logic [mcu_pkg::DMEM_DW-1:0]  core_wdata;
    logic [mcu_pkg::DMEM_DW-1:0]  core_rdata;
    logic                         core_stall;

    logic                         host_req;
    logic                         host_we;
    logic [mcu_pkg::DMEM_AW-1:0]  host_addr;
    logic [mcu_pkg::DMEM_DW-1:0]  host_wdata;
    logic                         host_gnt;
    logic                         host_ack;
    logic [mcu_pkg::DMEM_DW-1:0]  host_rdata;

    logic                         mem_en;
    logic                         mem_we;
    logic [mcu_pkg::DMEM_AW-1:0]  mem_addr;
    logic [mcu_pkg::DMEM_DW-1:0]  mem_wdata;
    logic [mcu_pkg::DMEM_DW-1:0]  mem_rdata;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        input  host_req, host_we, host_addr, host_wdata,
        input  mem_rdata,
        output core_rdata, core_stall,
        output host_gnt, host_ack, host_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        output host_req, host_we, host_addr, host_wdata,
        output mem_rdata,
        input  core_rdata, core_stall,
        input  host_gnt, host_ack, host_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dmem_arbiter_starve_counter.sv
// Saturating wait counter: counts cycles the host was eligible but denied,
// and flags when the host must be forced through.
module starve_counter #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic full
);

    localparam int CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(LIMIT);

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic          full_r;

    // Next count: clear dominates, increment saturates at the limit
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (clr) begin
            cnt_nxt_s = '0;
        end else if (inc && (cnt_r != CNT_MAX)) begin
            cnt_nxt_s = cnt_r + CW'(1);
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Count and full flag registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_r  <= '0;
            full_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_nxt_s;
            full_r <= (cnt_nxt_s == CNT_MAX);
        end
    end

    assign full = full_r;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data RAM between the core (priority) and the host
// port; a starvation counter forces a host access after a bounded wait.
module dmem_arbiter
    import mcu_pkg::*;
#(
    parameter int AW           = DMEM_AW,
    parameter int DW           = DMEM_DW,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave bus
);

    owner_t          grant_s;
    owner_t          owner_r;
    logic            host_elig_s;
    logic            starve_full_s;
    logic            starve_inc_s;
    logic            host_ack_r;
    logic            host_ack_s;
    logic            host_we_r;
    logic            host_rd_done_s;
    logic            mem_we_s;
    logic [AW-1:0]   mem_addr_s;
    logic [DW-1:0]   mem_wdata_s;
    logic [DW-1:0]   host_rdata_r;

    // The host cannot be granted again in the cycle its previous access is acked
    assign host_elig_s  = bus.host_req && !host_ack_r;
    assign starve_inc_s = host_elig_s && (grant_s != HOST);

    starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
        .clk  (clk),
        .rst  (rst),
        .inc  (starve_inc_s),
        .clr  (!starve_inc_s),
        .full (starve_full_s)
    );

    // Grant selection: starved host, then core, then idle host
    always_comb begin
        grant_s = NONE;
        if (!rst) begin
            grant_s = NONE;
        end else if (starve_full_s && host_elig_s) begin
            grant_s = HOST;
        end else if (bus.core_req) begin
            grant_s = CORE;
        end else if (host_elig_s) begin
            grant_s = HOST;
        end else begin
            grant_s = NONE;
        end
    end

    // RAM port steering from the winner
    always_comb begin
        mem_we_s    = 1'b0;
        mem_addr_s  = '0;
        mem_wdata_s = '0;
        case (grant_s)
            CORE: begin
                mem_we_s    = bus.core_we;
                mem_addr_s  = bus.core_addr;
                mem_wdata_s = bus.core_wdata;
            end
            HOST: begin
                mem_we_s    = bus.host_we;
                mem_addr_s  = bus.host_addr;
                mem_wdata_s = bus.host_wdata;
            end
            default: begin
                mem_we_s    = 1'b0;
                mem_addr_s  = '0;
                mem_wdata_s = '0;
            end
        endcase
    end

    // Host read data arrives from the RAM in the ack cycle and is then held
    assign host_ack_s     = host_ack_r && rst;
    assign host_rd_done_s = host_ack_s && (owner_r == HOST) && !host_we_r;

    // Ownership, host completion and held host read data
    always_ff @(posedge clk) begin
        if (!rst) begin
            owner_r      <= NONE;
            host_ack_r   <= 1'b0;
            host_we_r    <= 1'b0;
            host_rdata_r <= '0;
        end else begin
            owner_r    <= grant_s;
            host_ack_r <= (grant_s == HOST);
            if (grant_s == HOST) begin
                host_we_r <= bus.host_we;
            end else begin
                host_we_r <= host_we_r;
            end
            if (host_rd_done_s) begin
                host_rdata_r <= bus.mem_rdata;
            end else begin
                host_rdata_r <= host_rdata_r;
            end
        end
    end

    assign bus.mem_en     = (grant_s != NONE);
    assign bus.mem_we     = mem_we_s;
    assign bus.mem_addr   = mem_addr_s;
    assign bus.mem_wdata  = mem_wdata_s;
    assign bus.core_stall = rst && bus.core_req && (grant_s != CORE);
    assign bus.core_rdata = bus.mem_rdata;
    assign bus.host_gnt   = (grant_s == HOST);
    assign bus.host_ack   = host_ack_s;
    assign bus.host_rdata = host_rd_done_s ? bus.mem_rdata : host_rdata_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and randomized bench for dmem_arbiter, checked against a
// transaction-level model of arbitration and memory contents.
module tb_dmem_arbiter;

    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst;
    logic ram_clear;
    always #5 clk = ~clk;

    dmem_arbiter_if bus ();

    dmem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Synchronous 16x8 data RAM
    logic [7:0] ram [16];
    always @(posedge clk) begin
        if (ram_clear) begin
            for (int i = 0; i < 16; i++) ram[i] <= 8'h00;
            bus.mem_rdata <= 8'h00;
        end else if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata <= ram[bus.mem_addr];
        end
    end

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state
    logic [7:0] ref_mem [16];
    bit         m_ack;
    int         m_wait;
    bit         m_core_pend;
    logic [7:0] m_core_val;
    logic [7:0] m_host_rdata;
    bit         obs_gnt;
    bit         obs_ack;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic core_set(input bit req, input bit we, input logic [3:0] a, input logic [7:0] d);
        bus.core_req = req; bus.core_we = we; bus.core_addr = a; bus.core_wdata = d;
    endtask

    task automatic host_set(input bit req, input bit we, input logic [3:0] a, input logic [7:0] d);
        bus.host_req = req; bus.host_we = we; bus.host_addr = a; bus.host_wdata = d;
    endtask

    // One clock: check outputs at the falling edge, advance the model at the rising edge
    task automatic cycle();
        bit elig, hwin, cwin;
        @(negedge clk);
        obs_gnt = bus.host_gnt;
        obs_ack = bus.host_ack;
        if (!rst) begin
            chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
            chk("rst_host_gnt", 32'(bus.host_gnt), 32'd0);
            chk("rst_core_stall", 32'(bus.core_stall), 32'd0);
            chk("rst_host_ack", 32'(bus.host_ack), 32'd0);
            @(posedge clk);
            m_ack = 1'b0; m_wait = 0; m_core_pend = 1'b0; m_host_rdata = 8'h00;
            #1;
            return;
        end
        elig = bus.host_req && !m_ack;
        hwin = elig && ((m_wait >= LIMIT) || !bus.core_req);
        cwin = bus.core_req && !hwin;
        chk("mem_en", 32'(bus.mem_en), 32'(hwin || cwin));
        chk("host_gnt", 32'(bus.host_gnt), 32'(hwin));
        chk("core_stall", 32'(bus.core_stall), 32'(bus.core_req && !cwin));
        chk("host_ack", 32'(bus.host_ack), 32'(m_ack));
        chk("host_rdata", 32'(bus.host_rdata), 32'(m_host_rdata));
        if (m_core_pend) chk("core_rdata", 32'(bus.core_rdata), 32'(m_core_val));
        if (hwin) begin
            chk("mem_addr_h", 32'(bus.mem_addr), 32'(bus.host_addr));
            chk("mem_we_h", 32'(bus.mem_we), 32'(bus.host_we));
            if (bus.host_we) chk("mem_wdata_h", 32'(bus.mem_wdata), 32'(bus.host_wdata));
        end else if (cwin) begin
            chk("mem_addr_c", 32'(bus.mem_addr), 32'(bus.core_addr));
            chk("mem_we_c", 32'(bus.mem_we), 32'(bus.core_we));
            if (bus.core_we) chk("mem_wdata_c", 32'(bus.mem_wdata), 32'(bus.core_wdata));
        end
        @(posedge clk);
        m_core_pend = cwin && !bus.core_we;
        m_core_val  = ref_mem[bus.core_addr];
        if (cwin && bus.core_we) ref_mem[bus.core_addr] = bus.core_wdata;
        if (hwin) begin
            if (bus.host_we) ref_mem[bus.host_addr] = bus.host_wdata;
            else             m_host_rdata = ref_mem[bus.host_addr];
        end
        m_ack  = hwin;
        m_wait = (elig && !hwin) ? ((m_wait < LIMIT) ? m_wait + 1 : LIMIT) : 0;
        #1;
    endtask

    initial begin
        int gnt_cyc;
        int ack_cyc;
        logic [5:0] gnt_pat;
        logic [5:0] ack_pat;
        bit found;

        for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
        m_ack = 1'b0; m_wait = 0; m_core_pend = 1'b0; m_core_val = 8'h00; m_host_rdata = 8'h00;

        // Reset held with both requesters active
        rst = 1'b0; ram_clear = 1'b1;
        core_set(1'b1, 1'b0, 4'd0, 8'h00);
        host_set(1'b1, 1'b0, 4'd0, 8'h00);
        repeat (3) cycle();
        rst = 1'b1; ram_clear = 1'b0;
        core_set(1'b0, 1'b0, 4'd0, 8'h00);
        host_set(1'b0, 1'b0, 4'd0, 8'h00);
        cycle();

        // Uncontended core write then read
        core_set(1'b1, 1'b1, 4'd3, 8'hA5); cycle();
        core_set(1'b1, 1'b0, 4'd3, 8'h00); cycle();
        chk("core_read_no_stall", 32'(bus.core_stall), 32'd0);
        core_set(1'b0, 1'b0, 4'd0, 8'h00);
        @(negedge clk);
        chk("core_rdata_a5", 32'(bus.core_rdata), 32'hA5);
        @(posedge clk); #1;
        m_core_pend = 1'b0;

        // Uncontended host write then read
        host_set(1'b1, 1'b1, 4'd7, 8'h3C); cycle();
        chk("host_wr_gnt", 32'(obs_gnt), 32'd1);
        cycle();
        chk("host_wr_ack", 32'(obs_ack), 32'd1);
        host_set(1'b1, 1'b0, 4'd7, 8'h00); cycle();
        chk("host_rd_gnt", 32'(obs_gnt), 32'd1);
        cycle();
        chk("host_rd_ack", 32'(obs_ack), 32'd1);
        host_set(1'b0, 1'b0, 4'd0, 8'h00); cycle();
        chk("host_rdata_3c", 32'(bus.host_rdata), 32'h3C);

        // Starvation under continuous core traffic
        gnt_cyc = -1; ack_cyc = -1;
        host_set(1'b1, 1'b0, 4'd2, 8'h00);
        for (int i = 0; i < 8; i++) begin
            core_set(1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom));
            if (i == 6) host_set(1'b0, 1'b0, 4'd0, 8'h00);
            cycle();
            if (obs_gnt) gnt_cyc = i;
            if (obs_ack) ack_cyc = i;
        end
        chk("starve_gnt_cycle", 32'(gnt_cyc), 32'd4);
        chk("starve_ack_cycle", 32'(ack_cyc), 32'd5);
        core_set(1'b0, 1'b0, 4'd0, 8'h00); cycle();

        // Ack exclusion with host request held and core idle
        host_set(1'b1, 1'b0, 4'd7, 8'h00);
        for (int i = 0; i < 6; i++) begin
            cycle();
            gnt_pat[i] = obs_gnt;
            ack_pat[i] = obs_ack;
        end
        chk("excl_gnt_pattern", 32'(gnt_pat), 32'h15);
        chk("excl_ack_pattern", 32'(ack_pat), 32'h2A);
        host_set(1'b0, 1'b0, 4'd0, 8'h00); cycle(); cycle();

        // Reset in the cycle following a host grant
        core_set(1'b1, 1'b0, 4'd1, 8'h00);
        host_set(1'b1, 1'b0, 4'd2, 8'h00);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            cycle();
            found = obs_gnt;
        end
        chk("midrst_gnt_seen", 32'(found), 32'd1);
        rst = 1'b0; cycle();
        chk("midrst_no_ack", 32'(obs_ack), 32'd0);
        rst = 1'b1;
        gnt_cyc = -1;
        for (int i = 0; i < 8; i++) begin
            if (i == 6) host_set(1'b0, 1'b0, 4'd0, 8'h00);
            cycle();
            if (obs_gnt && gnt_cyc < 0) gnt_cyc = i;
        end
        chk("midrst_full_wait", 32'(gnt_cyc), 32'd4);

        // Randomized traffic with a well-behaved host
        core_set(1'b0, 1'b0, 4'd0, 8'h00);
        host_set(1'b0, 1'b0, 4'd0, 8'h00);
        for (int n = 0; n < 400; n++) begin
            core_set(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                     4'($urandom_range(0, 15)), 8'($urandom));
            if (!bus.host_req || m_ack) begin
                host_set(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                         4'($urandom_range(0, 15)), 8'($urandom));
            end
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the MCU's single-port 16x8 data memory between the core datapath and an external host/debug port. The core has priority so normal execution keeps single-cycle memory access. A starvation counter forces a host access after a bounded wait, stalling the core for exactly one cycle. The block sits between the core's data-memory bus and the data RAM inside the MCU top level.

## Interface

**Parameters**
- `AW`, 4, data-memory address width.
- `DW`, 8, data width.
- `STARVE_LIMIT`, 4, consecutive cycles of host denial after which the host wins (1..15).

**Ports**
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous and active-low.
- `core_req` in 1: core memory access this cycle.
- `core_we` in 1: core write enable.
- `core_addr` in AW: core address.
- `core_wdata` in DW: core write data.
- `core_rdata` out DW: core read data, valid the cycle after a granted core read.
- `core_stall` out 1: core access not issued this cycle; the core must hold its request.
- `host_req` in 1: host request; held with addr/we/wdata stable until `host_ack`.
- `host_we` in 1: host write enable.
- `host_addr` in AW: host address.
- `host_wdata` in DW: host write data.
- `host_gnt` out 1: host access issued to memory this cycle.
- `host_ack` out 1: registered; host access complete; `host_rdata` valid.
- `host_rdata` out DW: registered host read data.
- `mem_en`, `mem_we` out 1: RAM port controls.
- `mem_addr` out AW, `mem_wdata` out DW: RAM port.
- `mem_rdata` in DW: RAM read data, synchronous (1-cycle latency).

## Operation

**State registers**
- `owner` ∈ {NONE, CORE, HOST}: owner of the access issued last cycle.
- `starve_cnt`: width clog2(STARVE_LIMIT+1), saturating.
- `host_ack`, `host_rdata`.

**Host eligibility:** `host_req && !host_ack`. The host is never granted in its own ack cycle.

**Grant, combinational each cycle**
- `starve_cnt == STARVE_LIMIT` and host eligible → HOST.
- else `core_req` → CORE.
- else host eligible → HOST.
- else NONE.

**Outputs**
- `core_stall = core_req && grant != CORE`.
- `host_gnt = (grant == HOST)`.
- `mem_*` is driven from the winner.
- `mem_en = (grant != NONE)`.

**Starvation counter**
- Increments when host eligible and grant != HOST, saturating at STARVE_LIMIT.
- Clears on host grant or when the host is not eligible.

**Completion and data routing**
- Next cycle after a HOST grant: `host_ack = 1`; `host_rdata` is loaded from `mem_rdata` on the following edge if it was a read. For writes, `host_rdata` holds its value.
- `core_rdata = mem_rdata` combinationally; meaningful only when `owner == CORE`.

**Boundary conditions**
- Same-address core/host accesses are ordered strictly by grant cycle, with no bypass.
- The host dropping `host_req` before ack is illegal; the arbiter does not check for it.

**Reset (`rst` low at an edge)**
- `owner` = NONE, `starve_cnt` = 0, `host_ack` = 0, `host_rdata` = 0.
- While `rst` is low, grant is forced to NONE: `mem_en` = 0, `host_gnt` = 0, `core_stall` = 0.
- An in-flight host access is abandoned with no ack.

## Timing

- Core read: granted at cycle t, `core_rdata` valid at t+1. Zero added latency when uncontended.
- Host read or write: granted at cycle g, `host_ack` high for exactly one cycle at g+1.
  - Read: `host_rdata` valid from g+1 and held until the next host read completes.
- Worst-case host wait from `host_req` assertion to grant under continuous core traffic: STARVE_LIMIT cycles (grant on cycle STARVE_LIMIT+1).
- The core stalls at most one cycle per host access.
- Back-to-back host requests take a minimum of 2 cycles each, because of the ack-cycle exclusion.

## Structure

- Shared `mcu_pkg`:
  - `owner_t` enum {NONE, CORE, HOST}.
  - Data-memory `AW`/`DW` constants.
- One sub-module, `starve_counter`: saturating counter with inc/clr/full ports, parameterised by LIMIT.
- All remaining logic lives in `dmem_arbiter`.

## Test plan

- **Reset:** hold `rst` = 0 for 3 cycles with `core_req` = 1 and `host_req` = 1 → `mem_en` = 0, `host_gnt` = 0, `core_stall` = 0, `host_ack` = 0.
- **Uncontended core:** write 0xA5 to addr 3, then read addr 3 → `core_stall` never set; `core_rdata` = 0xA5 one cycle after the read.
- **Uncontended host:** write 0x3C to addr 7, then read addr 7 → `host_gnt` on the request cycle; `host_ack` next cycle; `host_rdata` = 0x3C.
- **Starvation, STARVE_LIMIT = 4:** `core_req` held high continuously; host read of addr 2 asserted at cycle 0 → `host_gnt` and `core_stall` at cycle 4 only; `host_ack` at cycle 5; core granted again at cycle 5.
- **Ack exclusion:** host holds `host_req` through ack with the core idle → grant cycles spaced 2 apart; `host_ack` pulses alternate.
- **Reset mid-operation:** assert reset in the cycle after `host_gnt` → no `host_ack`; `starve_cnt` = 0; first post-reset contended request waits the full STARVE_LIMIT.
